mem_access_unit: RTL and testbench

//  Parametrised load/store unit between the MEM pipeline stage and the data bus.

---
 rtl/mem_access_unit_if.sv | 40 ++++
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data-bus signals of mem_access_unit.
// slave = the unit's view; master = the pipeline plus bus environment driving it.
interface mem_access_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_ctrl;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_mmio;
  logic              resp_misalign;
  logic              busy;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [BYTES-1:0]  dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, flush, dresp_data_ok, dresp_data,
    output req_ready, resp_valid, resp_data, resp_mmio, resp_misalign, busy,
           dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, flush, dresp_data_ok, dresp_data,
    input  req_ready, resp_valid, resp_data, resp_mmio, resp_misalign, busy,
           dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one access in flight, response one cycle after data_ok; req_ready only when idle,
// bus request held until data_ok even across a flush. Option macro: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int MMIO_BIT = 31
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t            state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic              mmio_q;
  logic              ready_q;
  logic              busy_q;
  logic              resp_q;
  logic              resp_mmio_q;
  logic              resp_mis_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              dreq_valid_q;
  logic [ADDR_W-1:0] dreq_addr_q;
  logic [2:0]        dreq_size_q;
  logic [BYTES-1:0]  dreq_strobe_q;
  logic [DATA_W-1:0] dreq_data_q;
  logic [1:0]        req_size;
  logic [OFF_W-1:0]  req_off;

  // A doubleword access on a 32-bit bus is not representable; it degrades to a word.
  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    return (DATA_W == 32 && s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [BYTES-1:0] lane_strobe(input logic [1:0] s, input logic [OFF_W-1:0] off);
    logic [2*BYTES-1:0] ones;
    ones = '0;
    for (int i = 0; i < BYTES; i++) ones[i] = (i < (1 << s));
    ones = ones << off;
    return ones[BYTES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word, input logic [1:0] s,
                                                    input logic [OFF_W-1:0] off, input logic uns);
    int                nbits;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] hi_mask;
    logic [DATA_W-1:0] top;
    nbits = 8 << s;
    if (nbits >= DATA_W) return word;
    raw     = word >> {off, 3'b000};
    hi_mask = {DATA_W{1'b1}} << nbits;
    top     = raw >> (nbits - 1);
    return (raw & ~hi_mask) | ((top[0] && !uns) ? hi_mask : '0);
  endfunction

  assign req_size = clamp_size(bus.req_ctrl[1:0]);
  assign req_off  = bus.req_addr[OFF_W-1:0];

`ifdef MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis = (bus.req_addr[2:0] & 3'((1 << req_size) - 1)) != 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= '0;
      off_q         <= '0;
      mmio_q        <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      resp_q        <= 1'b0;
      resp_mmio_q   <= 1'b0;
      resp_mis_q    <= 1'b0;
      resp_data_q   <= '0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_ctrl[2];
            size_q  <= req_size;
            off_q   <= req_off;
            mmio_q  <= ~bus.req_addr[MMIO_BIT];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (req_mis) begin
              resp_q      <= 1'b1;
              resp_data_q <= '0;
              resp_mmio_q <= ~bus.req_addr[MMIO_BIT];
              resp_mis_q  <= 1'b1;
              state       <= DONE;
            end else begin
`endif
              dreq_valid_q  <= 1'b1;
              dreq_addr_q   <= bus.req_addr;
              dreq_size_q   <= {1'b0, req_size};
              dreq_strobe_q <= bus.req_we ? lane_strobe(req_size, req_off) : '0;
              dreq_data_q   <= bus.req_wdata << {req_off, 3'b000};
              state         <= WAIT;
`ifdef MISALIGN_TRAP_EN
            end
`endif
          end
        end
        WAIT: begin
          if (bus.dresp_data_ok) begin
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            if (bus.flush) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              resp_q      <= 1'b1;
              resp_data_q <= we_q ? '0 : load_extend(bus.dresp_data, size_q, off_q, uns_q);
              resp_mmio_q <= mmio_q;
              resp_mis_q  <= 1'b0;
              state       <= DONE;
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          resp_q      <= 1'b0;
          resp_data_q <= '0;
          resp_mmio_q <= 1'b0;
          resp_mis_q  <= 1'b0;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          // DRAIN: the bus still owes a data phase; swallow it silently.
          if (bus.dresp_data_ok) begin
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.busy          = busy_q;
  assign bus.resp_valid    = resp_q & ~bus.flush;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_mmio     = resp_mmio_q;
  assign bus.resp_misalign = resp_mis_q;
  assign bus.dreq_valid    = dreq_valid_q;
  assign bus.dreq_addr     = dreq_addr_q;
  assign bus.dreq_size     = dreq_size_q;
  assign bus.dreq_strobe   = dreq_strobe_q;
  assign bus.dreq_data     = dreq_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: byte-level reference model, directed cases plus random accesses.
module tb_mem_access_unit;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int BYTES = DW / 8;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [2:0]       size;
    logic [BYTES-1:0] strobe;
    logic [DW-1:0]    data;
  } dreq_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          mmio;
    logic          mis;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MMIO_BIT(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dreq_t dreq_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: byte lanes picked and sign-extended arithmetically.
  function automatic void model(input logic we, input logic [2:0] ctrl, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                output dreq_t d, output resp_t r);
    int            s;
    int            n;
    int            off;
    logic [DW-1:0] v;
    s = int'(ctrl[1:0]);
    if (DW == 32 && s == 3) s = 2;
    n   = 1 << s;
    off = int'(addr[2:0]) % BYTES;
    d.addr   = addr;
    d.size   = 3'(s);
    d.strobe = '0;
    d.data   = '0;
    for (int i = off; i < BYTES; i++) begin
      d.data[8*i +: 8] = wdata[8*(i-off) +: 8];
      if (we && i < off + n) d.strobe[i] = 1'b1;
    end
    v = '0;
    if (8 * n >= DW) v = rdata;
    else begin
      for (int k = 0; k < n && off + k < BYTES; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
      if (!ctrl[2] && v[8*n-1]) v = v - (64'd1 << (8 * n));
    end
    r.data = we ? '0 : v;
    r.mmio = !addr[31];
    r.mis  = (int'(addr[2:0]) % n) != 0;
  endfunction

  // Bus-request and response monitor.
  dreq_t held;
  bit    prev_v = 1'b0;
  always @(negedge clk) begin
    if (bus.dreq_valid === 1'b1) begin
      if (!prev_v) begin
        checks++;
        if (dreq_q.size() == 0) begin
          errors++;
          $display("FAIL dreq_unexpected: actual addr=%0h expected no request", bus.dreq_addr);
        end else begin
          dreq_t e;
          e = dreq_q.pop_front();
          check("dreq_addr", bus.dreq_addr, e.addr);
          check("dreq_size", 64'(bus.dreq_size), 64'(e.size));
          check("dreq_strobe", 64'(bus.dreq_strobe), 64'(e.strobe));
          check("dreq_data", bus.dreq_data, e.data);
        end
        held.addr   = bus.dreq_addr;
        held.size   = bus.dreq_size;
        held.strobe = bus.dreq_strobe;
        held.data   = bus.dreq_data;
      end else begin
        check("dreq_hold_addr", bus.dreq_addr, held.addr);
        check("dreq_hold_strobe", 64'(bus.dreq_strobe), 64'(held.strobe));
        check("dreq_hold_data", bus.dreq_data, held.data);
      end
    end
    prev_v = (bus.dreq_valid === 1'b1);
    if (bus.resp_valid === 1'b1) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: actual data=%0h expected no response", bus.resp_data);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_data", bus.resp_data, e.data);
        check("resp_mmio", 64'(bus.resp_mmio), 64'(e.mmio));
        check("resp_misalign", 64'(bus.resp_misalign), 64'(e.mis));
        check("resp_ready_low", 64'(bus.req_ready), 64'd0);
      end
    end
  end

  // fl: 0 none, 1 flush in WAIT, 2 flush with data_ok, 3 flush in DONE
  task automatic run(input logic we, input logic [2:0] ctrl, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input int lat, input int fl);
    dreq_t d;
    resp_t r;
    bit    trap;
    int    t;
    model(we, ctrl, addr, wdata, rdata, d, r);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = r.mis;
`endif
    if (trap && fl != 3) fl = 0;
    if (fl == 1 && lat == 0) lat = 1;
    t = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 64'(bus.req_ready), 64'd1);
    if (trap) begin
      r.data = '0;
      if (fl != 3) resp_q.push_back(r);
    end else begin
      dreq_q.push_back(d);
      r.mis = 1'b0;
      if (fl == 0) resp_q.push_back(r);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (trap) begin
      if (fl == 3) bus.flush = 1'b1;
      @(negedge clk);
      check("trap_resp_valid", 64'(bus.resp_valid), 64'(fl != 3));
      check("trap_no_dreq", 64'(bus.dreq_valid), 64'd0);
    end else begin
      for (int k = 0; k < lat; k++) begin
        if (k == 0 && fl == 1) bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
      end
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = rdata;
      bus.flush         = (fl == 2);
      @(posedge clk);
      #1 bus.dresp_data_ok = 1'b0;
      bus.dresp_data = {$urandom, $urandom};
      bus.flush      = (fl == 3);
      @(negedge clk);
      check("resp_valid_latency", 64'(bus.resp_valid), 64'(fl == 0));
      check("dreq_cleared", 64'(bus.dreq_valid), 64'd0);
    end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(bus.req_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic          we;
    logic [2:0]    ctrl;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    int            fl;
    dreq_t         d;
    resp_t         r;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_ctrl = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.flush = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
    check("rst_dreq_strobe", 64'(bus.dreq_strobe), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    check("rst_resp_misalign", 64'(bus.resp_misalign), 64'd0);

    run(1'b0, 3'd3, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 3, 0);
    run(1'b0, 3'd0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 0);
    run(1'b0, 3'd4, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 0);
    run(1'b1, 3'd1, 64'h8000_0006, 64'hBEEF, 64'd0, 2, 0);
    run(1'b0, 3'd2, 64'h1000_0000, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 3, 1);
    run(1'b0, 3'd2, 64'h1000_0004, 64'd0, 64'h8765_4321_0000_0000, 1, 0);
    run(1'b0, 3'd1, 64'h8000_0002, 64'd0, 64'h0000_0000_F00F_0000, 0, 2);
    run(1'b0, 3'd5, 64'h8000_0006, 64'd0, 64'hF00F_0000_0000_0000, 1, 3);
    run(1'b0, 3'd2, 64'h8000_0002, 64'd0, 64'h0000_1234_5678_0000, 1, 0);

    // Flush while presenting a request in IDLE: nothing may be accepted.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_ctrl = 3'd3; bus.req_addr = 64'h8000_0010;
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_dreq", 64'(bus.dreq_valid), 64'd0);
    check("idle_flush_ready", 64'(bus.req_ready), 64'd1);

    // Reset in the middle of a held bus request.
    model(1'b1, 3'd2, 64'h8000_0020, 64'h0102_0304, 64'd0, d, r);
    dreq_q.push_back(d);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_ctrl = 3'd2; bus.req_addr = 64'h8000_0020;
    bus.req_wdata = 64'h0102_0304;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);

    for (int n = 0; n < 150; n++) begin
      we    = 1'($urandom_range(0, 1));
      ctrl  = 3'($urandom_range(0, 7));
      addr  = {32'h0, ($urandom_range(0, 1) != 0 ? 32'h1000_0000 : 32'h8000_0000)} + 64'($urandom_range(0, 255));
      wdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      lat   = $urandom_range(0, 3);
      fl    = $urandom_range(0, 6);
      if (fl > 3) fl = 0;
      run(we, ctrl, addr, wdata, rdata, lat, fl);
    end

    repeat (3) @(negedge clk);
    check("dreq_queue_empty", 64'(dreq_q.size()), 64'd0);
    check("resp_queue_empty", 64'(resp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=completion");
    $fatal(1);
  end
endmodule
